// File: rtl/wb_regfile_stage_pkg.sv
// Shared widths, register-zero index and HI/LO select encoding for the write-back stage.
// These are also used by the MEM/WB register and the hazard unit.
package wb_regfile_stage_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int REG_CNT = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // HI/LO write selects carried down the pipe for MULT/DIV/MTHI/MTLO
  typedef enum logic [1:0] {
    HL_SEL_NONE = 2'b00,
    HL_SEL_LO   = 2'b01,
    HL_SEL_HI   = 2'b10,
    HL_SEL_BOTH = 2'b11
  } hl_sel_e;

  function automatic logic gpr_write_en(input logic valid, input logic regwrite,
                                        input logic [ADDR_W-1:0] regnum);
    return valid & regwrite & (regnum != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_regfile_stage_if.sv
// MEM/WB slot bundle consumed by the write-back stage.
interface wb_regfile_stage_if;
  import wb_regfile_stage_pkg::*;

  logic              wb_valid;
  logic [31:0]       wb_ir;
  logic [31:0]       wb_pc;
  logic [DATA_W-1:0] wb_r1;
  logic [DATA_W-1:0] wb_r2;
  logic [ADDR_W-1:0] wb_regnum;
  logic              wb_regwrite;
  logic              wb_lowrite;
  logic              wb_hiwrite;

  modport master (
    output wb_valid, wb_ir, wb_pc, wb_r1, wb_r2,
           wb_regnum, wb_regwrite, wb_lowrite, wb_hiwrite
  );

  modport slave (
    input  wb_valid, wb_ir, wb_pc, wb_r1, wb_r2,
           wb_regnum, wb_regwrite, wb_lowrite, wb_hiwrite
  );

endinterface

// File: rtl/wb_gpr_file.sv
// 32x32 GPR array, two async read ports, one write port, r0 hard-wired to zero.
// Define WB_BYPASS_EN to forward the in-flight write onto the read ports.
module wb_gpr_file
  import wb_regfile_stage_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  logic [DATA_W-1:0] regs [REG_CNT];

  // we is already qualified with waddr != 0, so regs[0] never leaves reset
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rs_data = (rs_addr == REG_ZERO) ? '0 : regs[rs_addr];
    rt_data = (rt_addr == REG_ZERO) ? '0 : regs[rt_addr];
`ifdef WB_BYPASS_EN
    if (we && (waddr == rs_addr)) rs_data = wdata;
    if (we && (waddr == rt_addr)) rt_data = wdata;
`endif
  end

endmodule

// File: rtl/wb_regfile_stage.sv
// MIPS write-back stage: commits GPR/HI/LO, serves ID reads, tracks retired count and last PC/IR.
// Define WB_BYPASS_EN for same-cycle write-through forwarding on GPR reads and hi/lo.
module wb_regfile_stage
  import wb_regfile_stage_pkg::*;
(
  input  logic                clk,
  input  logic                CLR,
  wb_regfile_stage_if.slave   wb,
  input  logic [ADDR_W-1:0]   rs_addr,
  input  logic [ADDR_W-1:0]   rt_addr,
  output logic [DATA_W-1:0]   rs_data,
  output logic [DATA_W-1:0]   rt_data,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo,
  output logic [31:0]         retire_cnt,
  output logic [31:0]         last_pc,
  output logic [31:0]         last_ir
);

  logic              commit;
  logic              gpr_we;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [31:0]       retire_q;
  logic [31:0]       last_pc_q;
  logic [31:0]       last_ir_q;

  // bubbles and flushed slots arrive with wb_valid low and must leave no trace
  assign commit = wb.wb_valid;
  assign gpr_we = gpr_write_en(commit, wb.wb_regwrite, wb.wb_regnum);
  assign hi_we  = commit & wb.wb_hiwrite;
  assign lo_we  = commit & wb.wb_lowrite;

  wb_gpr_file u_gpr (
    .clk     (clk),
    .clr     (CLR),
    .we      (gpr_we),
    .waddr   (wb.wb_regnum),
    .wdata   (wb.wb_r1),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      hi_q      <= '0;
      lo_q      <= '0;
      retire_q  <= '0;
      last_pc_q <= '0;
      last_ir_q <= '0;
    end else begin
      if (hi_we) hi_q <= wb.wb_r2;
      if (lo_we) lo_q <= wb.wb_r1;
      if (commit) begin
        retire_q  <= retire_q + 32'd1;
        last_pc_q <= wb.wb_pc;
        last_ir_q <= wb.wb_ir;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign hi = hi_we ? wb.wb_r2 : hi_q;
  assign lo = lo_we ? wb.wb_r1 : lo_q;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif

  assign retire_cnt = retire_q;
  assign last_pc    = last_pc_q;
  assign last_ir    = last_ir_q;

endmodule
